// File: rtl/trng_pkg.sv
// Shared types and defaults for the metastable-latch entropy harvester.
// Optional von Neumann debiaser is enabled by defining TRNG_HARVESTER_VN_DEBIAS_EN.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    CAPTURE,
    STALL
  } state_t;

  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_WORD_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_REP_LIMIT   = 16;

  // rep_cnt must be able to hold REP_LIMIT itself
  localparam int DEF_REP_W = $clog2(DEF_REP_LIMIT + 1);

  function automatic int rep_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/trng_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous latch output.
module trng_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_reg <= '0;
    else     chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/trng_harvester.sv
// Entropy harvester: release/freeze sequencing, XOR combine, optional debias, word packing, health test.
// Define TRNG_HARVESTER_VN_DEBIAS_EN to insert the von Neumann debiaser between capture and packing.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gen_en,
  input  logic [CHANNELS-1:0] cell_q,
  output logic                cell_freeze,
  output logic [WORD_W-1:0]   word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                health_fail
);

  localparam int REP_W = rep_width(REP_LIMIT);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  logic [CHANNELS-1:0] sync_q;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
      trng_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cell_q[gi]),
        .q   (sync_q[gi])
      );
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic              cell_freeze_reg;
  logic              first_reg;
  logic              last_raw_reg;
  logic [REP_W-1:0]  rep_cnt_reg;
  logic              health_fail_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [WORD_W-1:0] word_data_reg;
  logic              word_valid_reg;

  logic              raw;
  logic              capture;
  logic [REP_W-1:0]  rep_cnt_next;
  logic              health_trip;
  logic              emit;
  logic              emit_bit;
  logic              word_done;
  logic [WORD_W-1:0] done_word;
  logic              can_load;
  logic              load_capture;
  logic              load_stall;

  assign raw     = ^sync_q;
  assign capture = (state_reg == CAPTURE) && gen_en && !health_fail_reg;

  assign rep_cnt_next = (!first_reg && (raw == last_raw_reg)) ? rep_cnt_reg + REP_W'(1)
                                                              : REP_W'(1);
  assign health_trip  = capture && (rep_cnt_next == REP_W'(REP_LIMIT));

`ifdef TRNG_HARVESTER_VN_DEBIAS_EN
  logic pair_full_reg;
  logic pair_bit_reg;

  // A pair emits its first bit only when the two bits differ
  assign emit     = capture && pair_full_reg && (pair_bit_reg != raw);
  assign emit_bit = pair_bit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_full_reg <= 1'b0;
      pair_bit_reg  <= 1'b0;
    end else if (!gen_en) begin
      pair_full_reg <= 1'b0;
      pair_bit_reg  <= 1'b0;
    end else if (capture) begin
      pair_full_reg <= !pair_full_reg;
      pair_bit_reg  <= pair_full_reg ? 1'b0 : raw;
    end
  end
`else
  assign emit     = capture;
  assign emit_bit = raw;
`endif

  // Shifting in at the MSB leaves the first emitted bit in bit 0 once the word is full
  assign done_word    = {emit_bit, shift_reg[WORD_W-1:1]};
  assign word_done    = emit && (bit_cnt_reg == CNT_W'(WORD_W - 1));
  assign can_load     = !word_valid_reg || word_ready;
  assign load_capture = word_done && can_load && !health_trip;
  assign load_stall   = (state_reg == STALL) && gen_en && !health_fail_reg && can_load;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gen_en && !health_fail_reg) state_next = ARM;
      ARM:     state_next = SETTLE;
      SETTLE:  if (settle_cnt_reg == SET_W'(SYNC_STAGES - 1)) state_next = CAPTURE;
      CAPTURE: begin
        if (health_trip)                 state_next = IDLE;
        else if (word_done && !can_load) state_next = STALL;
        else                             state_next = ARM;
      end
      STALL:   if (can_load) state_next = ARM;
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && (!gen_en || health_fail_reg)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      settle_cnt_reg  <= '0;
      cell_freeze_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      settle_cnt_reg  <= (state_reg == SETTLE) ? settle_cnt_reg + SET_W'(1) : '0;
      cell_freeze_reg <= (state_next != ARM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_reg       <= 1'b1;
      last_raw_reg    <= 1'b0;
      rep_cnt_reg     <= '0;
      health_fail_reg <= 1'b0;
    end else begin
      if (health_trip) health_fail_reg <= 1'b1;
      if (!gen_en || state_reg == IDLE) begin
        first_reg   <= 1'b1;
        rep_cnt_reg <= '0;
      end else if (capture) begin
        first_reg    <= 1'b0;
        last_raw_reg <= raw;
        rep_cnt_reg  <= rep_cnt_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (!gen_en) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (emit) begin
      // A completed word that cannot be loaded stays here while the FSM stalls
      if (word_done) begin
        shift_reg   <= (load_capture || health_trip) ? '0 : done_word;
        bit_cnt_reg <= '0;
      end else begin
        shift_reg   <= done_word;
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
    end else if (load_stall) begin
      shift_reg <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
    end else if (load_capture) begin
      word_data_reg  <= done_word;
      word_valid_reg <= 1'b1;
    end else if (load_stall) begin
      word_data_reg  <= shift_reg;
      word_valid_reg <= 1'b1;
    end else if (word_valid_reg && word_ready) begin
      word_valid_reg <= 1'b0;
    end
  end

  assign cell_freeze = cell_freeze_reg;
  assign word_data   = word_data_reg;
  assign word_valid  = word_valid_reg;
  assign health_fail = health_fail_reg;

endmodule

// File: tb/tb_trng_harvester.sv
// Self-checking bench for trng_harvester with a queue-based reference model of harvesting.
// Expectations follow TRNG_HARVESTER_VN_DEBIAS_EN the same way the design does.
module tb_trng_harvester;

  localparam int CH  = 8;
  localparam int W   = 8;
  localparam int S   = 2;
  localparam int REP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gen_en = 1'b0;
  logic [CH-1:0] cell_q = '0;
  logic          cell_freeze;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          health_fail;

  trng_harvester #(
    .CHANNELS    (CH),
    .WORD_W      (W),
    .SYNC_STAGES (S),
    .REP_LIMIT   (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gen_en      (gen_en),
    .cell_q      (cell_q),
    .cell_freeze (cell_freeze),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit           raw_stim[$];
  logic [W-1:0] exp_words[$];
  logic [W-1:0] got_words[$];
  int           cap_count = 0;
  int           stab_viol = 0;

  // reference model state: bits awaiting packing, open pair, run length
  bit m_bits[$];
  bit m_pair[$];
  int m_rep   = 0;
  bit m_last  = 1'b0;
  bit m_first = 1'b1;
  bit m_fail  = 1'b0;

  task automatic model_clear();
    m_bits.delete();
    m_pair.delete();
    m_rep   = 0;
    m_first = 1'b1;
  endtask

  task automatic model_feed(input bit r);
    logic [W-1:0] w;
    if (m_first || r != m_last) m_rep = 1;
    else                        m_rep = m_rep + 1;
    m_first = 1'b0;
    m_last  = r;
    if (m_rep == REP) m_fail = 1'b1;
`ifdef TRNG_HARVESTER_VN_DEBIAS_EN
    m_pair.push_back(r);
    if (m_pair.size() == 2) begin
      if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
      m_pair.delete();
    end
`else
    m_bits.push_back(r);
`endif
    if (m_bits.size() == W) begin
      if (!m_fail) begin
        w = '0;
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        exp_words.push_back(w);
      end
      m_bits.delete();
    end
  endtask

  // Cell driver: on each release pulse present the next raw bit, then log it if the capture completes
  initial begin
    forever begin
      @(negedge clk); #1;
      while (!rst && cell_freeze == 1'b0) begin
        bit            r;
        bit            ok;
        logic [CH-1:0] v;
        if (raw_stim.size() > 0) r = raw_stim.pop_front();
        else                     r = 1'($urandom);
        v = CH'($urandom);
        if ((^v) != r) v[0] = ~v[0];
        cell_q = v;
        ok = gen_en;
        for (int i = 0; i < S + 1; i++) begin
          @(negedge clk); #1;
          ok = ok && gen_en && !rst && !health_fail;
        end
        @(negedge clk); #1;
        if (ok && !rst) begin
          cap_count++;
          model_feed(r);
        end
      end
    end
  end

  // Output monitor: collect transfers, watch data stability, mirror partial discard on gen_en low
  initial begin
    logic         prev_hold;
    logic [W-1:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst && word_valid && word_ready) got_words.push_back(word_data);
      if (!rst && prev_hold && word_valid && word_data != prev_data) stab_viol++;
      prev_hold = word_valid && !word_ready && !rst;
      prev_data = word_data;
      #1;
      if (!gen_en) model_clear();
    end
  end

  task automatic clear_all();
    raw_stim.delete();
    exp_words.delete();
    got_words.delete();
    model_clear();
    m_fail    = 1'b0;
    cap_count = 0;
    stab_viol = 0;
  endtask

  task automatic do_reset(input bit gen);
    @(negedge clk);
    rst = 1'b1; gen_en = gen; word_ready = 1'b0;
    repeat (3) @(negedge clk);
    clear_all();
    rst = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (got_words.size() < n && c < budget) begin
      @(negedge clk); c++;
    end
  endtask

  task automatic wait_caps(input int n, input int budget);
    int c = 0;
    while (cap_count < n && c < budget) begin
      @(negedge clk); #2; c++;
    end
  endtask

  task automatic gen_stim(input int n);
    bit b; bit last; int run;
    last = 1'b0; run = 0;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom);
      if (i > 0 && b == last && run >= 6) b = ~b;
      run  = (i > 0 && b == last) ? run + 1 : 1;
      last = b;
      raw_stim.push_back(b);
    end
  endtask

  task automatic test_reset();
    logic f [8];
    @(negedge clk);
    rst = 1'b1; gen_en = 1'b1; word_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (cell_freeze !== 1'b1) begin bad++; $display("FAIL reset_freeze: got %b expected 1", cell_freeze); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health: got %b expected 0", health_fail); end
    total++; if (word_data !== '0) begin bad++; $display("FAIL reset_data: got %h expected 00", word_data); end
    @(negedge clk);
    clear_all();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      f[i] = cell_freeze;
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (f[i] !== ((i % 4) != 0)) begin
        bad++; $display("FAIL arm_timing[%0d]: got %b expected %b", i, f[i], (i % 4) != 0);
      end
    end
    $display("reset/arm timing checked");
  endtask

  task automatic test_alternating(input bit first);
    int           n;
    logic [W-1:0] ex0;
`ifdef TRNG_HARVESTER_VN_DEBIAS_EN
    n   = 1;
    ex0 = first ? 8'hFF : 8'h00;
`else
    n   = 2;
    ex0 = first ? 8'h55 : 8'hAA;
`endif
    do_reset(1'b1);
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raw_stim.push_back(first);
      raw_stim.push_back(~first);
    end
    wait_words(n, 400);
    total++;
    if (got_words.size() < n || exp_words.size() < n) begin
      bad++; $display("FAIL alt_timeout: got %0d words expected %0d", got_words.size(), n);
    end else begin
      total++; if (got_words[0] !== ex0) begin bad++; $display("FAIL alt_const: got %h expected %h", got_words[0], ex0); end
      for (int i = 0; i < n; i++) begin
        total++;
        if (got_words[i] !== exp_words[i]) begin
          bad++; $display("FAIL alt_word[%0d]: got %h expected %h", i, got_words[i], exp_words[i]);
        end
      end
      $display("alternating start=%0d word=%h", first, got_words[0]);
    end
  endtask

  task automatic test_pairs();
    bit           pre [6] = '{1, 1, 0, 0, 1, 0};
    logic [W-1:0] msk;
    logic [W-1:0] ex0;
`ifdef TRNG_HARVESTER_VN_DEBIAS_EN
    msk = 8'hFF; ex0 = 8'h01;
`else
    msk = 8'h3F; ex0 = 8'h13;
`endif
    do_reset(1'b1);
    word_ready = 1'b1;
    for (int i = 0; i < 6; i++) raw_stim.push_back(pre[i]);
    for (int i = 0; i < 8; i++) begin raw_stim.push_back(1'b0); raw_stim.push_back(1'b1); end
    wait_words(1, 400);
    total++;
    if (got_words.size() < 1 || exp_words.size() < 1) begin
      bad++; $display("FAIL pairs_timeout: got %0d words expected 1", got_words.size());
    end else begin
      total++; if ((got_words[0] & msk) !== ex0) begin bad++; $display("FAIL pairs_const: got %h expected %h", got_words[0] & msk, ex0); end
      total++; if (got_words[0] !== exp_words[0]) begin bad++; $display("FAIL pairs_word: got %h expected %h", got_words[0], exp_words[0]); end
      $display("pairs word=%h", got_words[0]);
    end
  endtask

  task automatic test_backpressure();
    int c0; int fz; int c;
    do_reset(1'b1);
    gen_stim(400);
    c = 0;
    while (exp_words.size() < 2 && c < 3000) begin @(negedge clk); c++; end
    total++;
    if (exp_words.size() < 2) begin
      bad++; $display("FAIL bp_timeout: got %0d words expected 2", exp_words.size());
    end else begin
      c0 = cap_count; fz = 0;
      repeat (3 * (S + 2) + 4) begin
        @(negedge clk); #1;
        if (cell_freeze !== 1'b1) fz++;
      end
      total++; if (cap_count != c0) begin bad++; $display("FAIL bp_no_capture: got %0d captures expected %0d", cap_count, c0); end
      total++; if (fz != 0) begin bad++; $display("FAIL bp_freeze: got %0d released cycles expected 0", fz); end
      total++; if (word_valid !== 1'b1 || word_data !== exp_words[0]) begin
        bad++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", word_valid, word_data, exp_words[0]);
      end
      @(negedge clk); word_ready = 1'b1;
      @(negedge clk); #1;
      total++; if (word_valid !== 1'b1 || word_data !== exp_words[1]) begin
        bad++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", word_valid, word_data, exp_words[1]);
      end
      wait_words(2, 400);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_words.size() <= i || got_words[i] !== exp_words[i]) begin
          bad++; $display("FAIL bp_word[%0d]: got %h expected %h", i, (got_words.size() > i) ? got_words[i] : 'x, exp_words[i]);
        end
      end
      total++; if (stab_viol != 0) begin bad++; $display("FAIL bp_stable: got %0d changes expected 0", stab_viol); end
      $display("backpressure words=%h,%h", exp_words[0], exp_words[1]);
    end
  endtask

  task automatic test_health();
    int c0; int fz;
    do_reset(1'b1);
    word_ready = 1'b1;
    for (int i = 0; i < REP; i++) raw_stim.push_back(1'b0);
    wait_caps(REP - 1, 400);
    total++; if (cap_count != REP - 1 || health_fail !== 1'b0) begin
      bad++; $display("FAIL health_early: got caps=%0d hf=%b expected caps=%0d hf=0", cap_count, health_fail, REP - 1);
    end
    wait_caps(REP, 100);
    total++; if (cap_count != REP || health_fail !== 1'b1) begin
      bad++; $display("FAIL health_trip: got caps=%0d hf=%b expected caps=%0d hf=1", cap_count, health_fail, REP);
    end
    c0 = cap_count; fz = 0;
    repeat (12) begin @(negedge clk); #1; if (cell_freeze !== 1'b1) fz++; end
    @(negedge clk); gen_en = 1'b0;
    repeat (3) @(negedge clk);
    gen_en = 1'b1;
    repeat (10) begin @(negedge clk); #1; if (cell_freeze !== 1'b1) fz++; end
    total++; if (fz != 0 || cap_count != c0) begin
      bad++; $display("FAIL health_idle: got released=%0d caps=%0d expected 0 and %0d", fz, cap_count, c0);
    end
    total++; if (health_fail !== 1'b1) begin bad++; $display("FAIL health_sticky: got %b expected 1", health_fail); end
    total++; if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL health_words: got %0d words expected %0d", got_words.size(), exp_words.size());
    end
    do_reset(1'b0);
    @(negedge clk); #1;
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL health_clear: got %b expected 0", health_fail); end
    $display("health test tripped after %0d captures", c0);
  endtask

  task automatic test_gen_en_drop();
    int           base;
    logic [W-1:0] ex0;
`ifdef TRNG_HARVESTER_VN_DEBIAS_EN
    ex0 = 8'h00;
`else
    ex0 = 8'h80;
`endif
    do_reset(1'b1);
    word_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin raw_stim.push_back(1'b1); raw_stim.push_back(1'b0); end
    for (int i = 0; i < 12; i++) raw_stim.push_back(1'b0);
    wait_caps(22, 400);
    @(negedge clk); gen_en = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL drop_pre_count: got %0d words expected %0d", got_words.size(), exp_words.size());
    end
    got_words.delete(); exp_words.delete(); raw_stim.delete();
    for (int i = 0; i < 6; i++) raw_stim.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin raw_stim.push_back(1'b0); raw_stim.push_back(1'b1); end
    base = cap_count;
    gen_en = 1'b1;
    wait_caps(base + 22, 400);
    wait_words(1, 20);
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL drop_rep_restart: got hf=%b expected 0", health_fail); end
    total++;
    if (got_words.size() < 1 || exp_words.size() < 1) begin
      bad++; $display("FAIL drop_timeout: got %0d words expected 1", got_words.size());
    end else begin
      total++; if (got_words[0] !== ex0) begin bad++; $display("FAIL drop_const: got %h expected %h", got_words[0], ex0); end
      total++; if (got_words[0] !== exp_words[0]) begin bad++; $display("FAIL drop_word: got %h expected %h", got_words[0], exp_words[0]); end
      $display("gen_en drop: post word=%h", got_words[0]);
    end
  endtask

  task automatic test_random();
    int c = 0;
    do_reset(1'b1);
    gen_stim(600);
    while (got_words.size() < 6 && c < 8000) begin
      @(negedge clk);
      word_ready = 1'($urandom);
      c++;
    end
    total++;
    if (got_words.size() < 6) begin
      bad++; $display("FAIL rand_timeout: got %0d words expected 6", got_words.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (exp_words.size() <= i || got_words[i] !== exp_words[i]) begin
          bad++; $display("FAIL rand_word[%0d]: got %h expected %h", i, got_words[i], (exp_words.size() > i) ? exp_words[i] : 'x);
        end else begin
          $display("random word %0d = %h", i, got_words[i]);
        end
      end
    end
    total++; if (stab_viol != 0) begin bad++; $display("FAIL rand_stable: got %0d changes expected 0", stab_viol); end
  endtask

  initial begin
    test_reset();
    test_alternating(1'b1);
    test_alternating(1'b0);
    test_pairs();
    test_backpressure();
    test_health();
    test_gen_en_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
